// File: rtl/wb_write_buffer_pkg.sv
// Shared widths and entry layout for the writeback buffer in front of the
// 32x32 register file write port.
package wb_write_buffer_pkg;

    localparam int REG_AW    = 5;
    localparam int REG_DW    = 32;
    localparam int WBB_DEPTH = 4;

    typedef struct packed {
        logic [REG_AW-1:0] wn;
        logic [REG_DW-1:0] d;
    } wb_entry_t;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_write_buffer_if.sv
// Producer, regfile write and regfile read/forwarding signals of the buffer.
// Handshake: a result on port X transfers at a posedge only when vX=1 and
// rdy=1 in that cycle; producers hold results while rdy=0.
interface wb_write_buffer_if
    import wb_write_buffer_pkg::*;
#(
    parameter int DEPTH = WBB_DEPTH,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) ();
    localparam int CW = count_width(DEPTH);

    logic          v0;
    logic [AW-1:0] wn0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] wn1;
    logic [DW-1:0] d1;
    logic          rdy;

    logic          we;
    logic [AW-1:0] wn;
    logic [DW-1:0] d;

    logic [AW-1:0] rna;
    logic [AW-1:0] rnb;
    logic [DW-1:0] qa_rf;
    logic [DW-1:0] qb_rf;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic          hita;
    logic          hitb;

    logic          empty;
    logic [CW-1:0] count;

    modport master (
        output v0, wn0, d0, v1, wn1, d1, rna, rnb, qa_rf, qb_rf,
        input  rdy, we, wn, d, qa, qb, hita, hitb, empty, count
    );

    modport slave (
        input  v0, wn0, d0, v1, wn1, d1, rna, rnb, qa_rf, qb_rf,
        output rdy, we, wn, d, qa, qb, hita, hitb, empty, count
    );
endinterface

// File: rtl/wb_write_buffer_fwd_match.sv
// Youngest-first search of the pending entries for one read port register
// number; the head entry being written this cycle still counts as pending.
module wb_fwd_match #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic [PW-1:0]             head,
    input  logic [CW-1:0]             count,
    input  logic [DEPTH-1:0][AW-1:0]  ent_wn,
    input  logic [DEPTH-1:0][DW-1:0]  ent_d,
    input  logic [AW-1:0]             rn,
    output logic                      hit,
    output logic [DW-1:0]             data
);
    logic [PW-1:0] idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (rn != '0) && (ent_wn[idx] == rn)) begin
                hit  = 1'b1;
                data = ent_d[idx];
            end
        end
    end
endmodule

// File: rtl/wb_write_buffer.sv
// Two-in, one-out in-order writeback queue draining onto the regfile write
// port, with forwarding of pending results to both regfile read ports.
module wb_write_buffer
    import wb_write_buffer_pkg::*;
#(
    parameter int DEPTH = WBB_DEPTH,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input logic               clk,
    input logic               clr,
    wb_write_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0] mem_wn;
    logic [DEPTH-1:0][DW-1:0] mem_d;
    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;
    logic [CW-1:0]            count;
    logic [CW:0]              room;
    logic                     pop;
    logic                     rdy;
    logic                     st0;
    logic                     st1;
    logic                     hit_a;
    logic                     hit_b;
    logic [DW-1:0]            fwd_a;
    logic [DW-1:0]            fwd_b;

    assign pop  = (count != '0);
    // The head pops at the same edge, so its slot is free for this cycle's results.
    assign room = (CW+1)'(DEPTH) - (CW+1)'(count) + (CW+1)'(pop);
    assign rdy  = (room >= (CW+1)'(2));
    assign st0  = bus.v0 && rdy && (bus.wn0 != '0);
    assign st1  = bus.v1 && rdy && (bus.wn1 != '0);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            mem_wn <= '0;
            mem_d  <= '0;
        end else begin
            if (st0) begin
                mem_wn[tail] <= bus.wn0;
                mem_d[tail]  <= bus.d0;
            end
            if (st1) begin
                mem_wn[tail + PW'(st0)] <= bus.wn1;
                mem_d[tail + PW'(st0)]  <= bus.d1;
            end
            tail  <= tail + PW'(st0) + PW'(st1);
            head  <= head + PW'(pop);
            count <= count + CW'(st0) + CW'(st1) - CW'(pop);
        end
    end

    assign bus.rdy   = rdy;
    assign bus.we    = pop;
    assign bus.wn    = pop ? mem_wn[head] : '0;
    assign bus.d     = pop ? mem_d[head] : '0;
    assign bus.empty = !pop;
    assign bus.count = count;

    wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match_a (
        .head   (head),
        .count  (count),
        .ent_wn (mem_wn),
        .ent_d  (mem_d),
        .rn     (bus.rna),
        .hit    (hit_a),
        .data   (fwd_a)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match_b (
        .head   (head),
        .count  (count),
        .ent_wn (mem_wn),
        .ent_d  (mem_d),
        .rn     (bus.rnb),
        .hit    (hit_b),
        .data   (fwd_b)
    );

    // r0 reads as zero regardless of what the regfile presents.
    assign bus.qa   = hit_a ? fwd_a : ((bus.rna == '0) ? '0 : bus.qa_rf);
    assign bus.qb   = hit_b ? fwd_b : ((bus.rnb == '0) ? '0 : bus.qb_rf);
    assign bus.hita = hit_a;
    assign bus.hitb = hit_b;
endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed and random checks of the writeback buffer against hand-computed
// values and a small queue/regfile reference model.
module tb_wb_write_buffer;

    logic clk;
    logic clr;
    int   errors = 0;
    int   checks = 0;

    wb_write_buffer_if bus ();

    wb_write_buffer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs;
        bus.v0 = 1'b0; bus.wn0 = '0; bus.d0 = '0;
        bus.v1 = 1'b0; bus.wn1 = '0; bus.d1 = '0;
        bus.rna = '0; bus.rnb = '0; bus.qa_rf = '0; bus.qb_rf = '0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clr = 1'b1;
        idle_inputs();
        #1;
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0h want=0", bus.we); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        checks++; if (bus.empty !== 1'b1 || bus.rdy !== 1'b1) begin errors++; $display("FAIL reset_flags got empty=%0b rdy=%0b want 1 1", bus.empty, bus.rdy); end
        checks++; if (bus.hita !== 1'b0 || bus.hitb !== 1'b0) begin errors++; $display("FAIL reset_hit got=%0b%0b want=00", bus.hita, bus.hitb); end
        tick();
        clr = 1'b0;
        // fill to count=3 mid-drain
        bus.v0 = 1'b1; bus.wn0 = 5'd1; bus.d0 = 32'h101;
        bus.v1 = 1'b1; bus.wn1 = 5'd2; bus.d1 = 32'h102;
        tick();
        bus.wn0 = 5'd3; bus.d0 = 32'h103;
        bus.wn1 = 5'd4; bus.d1 = 32'h104;
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.count !== 3'd3 || bus.we !== 1'b1 || bus.wn !== 5'd2) begin errors++; $display("FAIL middrain_pre got count=%0d we=%0b wn=%0d want 3 1 2", bus.count, bus.we, bus.wn); end
        clr = 1'b1;
        #1;
        checks++; if (bus.we !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL async_clr got we=%0b count=%0d want 0 0", bus.we, bus.count); end
        tick();
        clr = 1'b0;
        #1;
        checks++; if (bus.we !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.rdy !== 1'b1) begin errors++; $display("FAIL clr_next got we=%0b count=%0d empty=%0b rdy=%0b want 0 0 1 1", bus.we, bus.count, bus.empty, bus.rdy); end
        checks++; if (bus.wn !== 5'd0 || bus.d !== 32'd0) begin errors++; $display("FAIL clr_wd got wn=%0d d=%0h want 0 0", bus.wn, bus.d); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL clr_nowrite cycle=%0d got we=%0b want 0", i, bus.we); end
        end
    endtask

    task automatic test_single;
        bus.v0 = 1'b1; bus.wn0 = 5'd5; bus.d0 = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.we !== 1'b0 || bus.rdy !== 1'b1) begin errors++; $display("FAIL single_pre got we=%0b rdy=%0b want 0 1", bus.we, bus.rdy); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.we !== 1'b1 || bus.wn !== 5'd5 || bus.d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_write got we=%0b wn=%0d d=%0h want 1 5 deadbeef", bus.we, bus.wn, bus.d); end
        checks++; if (bus.count !== 3'd1 || bus.empty !== 1'b0) begin errors++; $display("FAIL single_count got count=%0d empty=%0b want 1 0", bus.count, bus.empty); end
        tick();
        checks++; if (bus.we !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL single_after got we=%0b empty=%0b want 0 1", bus.we, bus.empty); end
    endtask

    task automatic test_dual_order;
        bus.v0 = 1'b1; bus.wn0 = 5'd3; bus.d0 = 32'h11;
        bus.v1 = 1'b1; bus.wn1 = 5'd3; bus.d1 = 32'h22;
        tick();
        idle_inputs();
        bus.rna = 5'd3; bus.qa_rf = 32'h99;
        #1;
        checks++; if (bus.we !== 1'b1 || bus.wn !== 5'd3 || bus.d !== 32'h11) begin errors++; $display("FAIL dual_first got we=%0b wn=%0d d=%0h want 1 3 11", bus.we, bus.wn, bus.d); end
        checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL dual_count got=%0d want=2", bus.count); end
        checks++; if (bus.qa !== 32'h22 || bus.hita !== 1'b1) begin errors++; $display("FAIL dual_fwd_young got qa=%0h hita=%0b want 22 1", bus.qa, bus.hita); end
        tick();
        checks++; if (bus.we !== 1'b1 || bus.wn !== 5'd3 || bus.d !== 32'h22) begin errors++; $display("FAIL dual_second got we=%0b wn=%0d d=%0h want 1 3 22", bus.we, bus.wn, bus.d); end
        checks++; if (bus.qa !== 32'h22 || bus.hita !== 1'b1) begin errors++; $display("FAIL dual_fwd_head got qa=%0h hita=%0b want 22 1", bus.qa, bus.hita); end
        tick();
        checks++; if (bus.we !== 1'b0 || bus.qa !== 32'h99 || bus.hita !== 1'b0) begin errors++; $display("FAIL dual_drained got we=%0b qa=%0h hita=%0b want 0 99 0", bus.we, bus.qa, bus.hita); end
        idle_inputs();
    endtask

    task automatic test_backpressure;
        bus.v0 = 1'b1; bus.wn0 = 5'd1; bus.d0 = 32'hA1;
        bus.v1 = 1'b1; bus.wn1 = 5'd2; bus.d1 = 32'hA2;
        tick();
        bus.wn0 = 5'd3; bus.d0 = 32'hA3;
        bus.wn1 = 5'd4; bus.d1 = 32'hA4;
        #1;
        checks++; if (bus.rdy !== 1'b1 || bus.count !== 3'd2) begin errors++; $display("FAIL bp_c2 got rdy=%0b count=%0d want 1 2", bus.rdy, bus.count); end
        tick();
        bus.wn0 = 5'd5; bus.d0 = 32'hA5;
        bus.wn1 = 5'd6; bus.d1 = 32'hA6;
        #1;
        checks++; if (bus.rdy !== 1'b1 || bus.count !== 3'd3) begin errors++; $display("FAIL bp_c3 got rdy=%0b count=%0d want 1 3", bus.rdy, bus.count); end
        tick();
        bus.v1 = 1'b0;
        bus.v0 = 1'b1; bus.wn0 = 5'd7; bus.d0 = 32'h77;
        #1;
        checks++; if (bus.rdy !== 1'b0 || bus.count !== 3'd4) begin errors++; $display("FAIL bp_full got rdy=%0b count=%0d want 0 4", bus.rdy, bus.count); end
        checks++; if (bus.wn !== 5'd3 || bus.d !== 32'hA3) begin errors++; $display("FAIL bp_head got wn=%0d d=%0h want 3 a3", bus.wn, bus.d); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.count !== 3'd3 || bus.rdy !== 1'b1 || bus.wn !== 5'd4) begin errors++; $display("FAIL bp_ignored got count=%0d rdy=%0b wn=%0d want 3 1 4", bus.count, bus.rdy, bus.wn); end
        tick();
        checks++; if (bus.wn !== 5'd5 || bus.d !== 32'hA5) begin errors++; $display("FAIL bp_drain5 got wn=%0d d=%0h want 5 a5", bus.wn, bus.d); end
        tick();
        checks++; if (bus.wn !== 5'd6 || bus.d !== 32'hA6 || bus.count !== 3'd1) begin errors++; $display("FAIL bp_drain6 got wn=%0d d=%0h count=%0d want 6 a6 1", bus.wn, bus.d, bus.count); end
        tick();
        checks++; if (bus.empty !== 1'b1 || bus.we !== 1'b0) begin errors++; $display("FAIL bp_empty got empty=%0b we=%0b want 1 0", bus.empty, bus.we); end
    endtask

    task automatic test_r0;
        bus.v1 = 1'b1; bus.wn1 = 5'd0; bus.d1 = 32'hAB;
        tick();
        idle_inputs();
        bus.rna = 5'd0; bus.qa_rf = 32'h55;
        #1;
        checks++; if (bus.count !== 3'd0 || bus.we !== 1'b0) begin errors++; $display("FAIL r0_nostore got count=%0d we=%0b want 0 0", bus.count, bus.we); end
        checks++; if (bus.qa !== 32'd0 || bus.hita !== 1'b0) begin errors++; $display("FAIL r0_read got qa=%0h hita=%0b want 0 0", bus.qa, bus.hita); end
        idle_inputs();
    endtask

    task automatic test_miss;
        bus.v0 = 1'b1; bus.wn0 = 5'd9; bus.d0 = 32'h1;
        bus.rna = 5'd9; bus.qa_rf = 32'h33;
        #1;
        checks++; if (bus.qa !== 32'h33 || bus.hita !== 1'b0) begin errors++; $display("FAIL nofwd_input got qa=%0h hita=%0b want 33 0", bus.qa, bus.hita); end
        tick();
        idle_inputs();
        bus.rnb = 5'd7; bus.qb_rf = 32'h1234;
        #1;
        checks++; if (bus.qb !== 32'h1234 || bus.hitb !== 1'b0) begin errors++; $display("FAIL miss_b got qb=%0h hitb=%0b want 1234 0", bus.qb, bus.hitb); end
        bus.rnb = 5'd9;
        #1;
        checks++; if (bus.qb !== 32'h1 || bus.hitb !== 1'b1) begin errors++; $display("FAIL hit_b got qb=%0h hitb=%0b want 1 1", bus.qb, bus.hitb); end
        tick();
        idle_inputs();
    endtask

    task automatic test_random;
        logic [36:0] exp_q[$];
        logic [31:0] exp_rf [32];
        logic [31:0] dut_rf [32];
        logic [31:0] eqa, eqb;
        logic        eha, ehb, erdy;
        int          mcnt;
        for (int r = 0; r < 32; r++) begin exp_rf[r] = '0; dut_rf[r] = '0; end
        for (int c = 0; c < 170; c++) begin
            mcnt = exp_q.size();
            erdy = (4 - mcnt + ((mcnt != 0) ? 1 : 0)) >= 2;
            if (c < 150) begin
                bus.v0 = 1'($urandom_range(0, 1)); bus.wn0 = 5'($urandom_range(0, 7)); bus.d0 = $urandom;
                bus.v1 = 1'($urandom_range(0, 1)); bus.wn1 = 5'($urandom_range(0, 7)); bus.d1 = $urandom;
                if (!erdy && $urandom_range(0, 3) != 0) begin bus.v0 = 1'b0; bus.v1 = 1'b0; end
            end else begin
                bus.v0 = 1'b0; bus.v1 = 1'b0;
            end
            bus.rna = 5'($urandom_range(0, 7)); bus.qa_rf = $urandom;
            bus.rnb = 5'($urandom_range(0, 7)); bus.qb_rf = $urandom;
            #1;
            eha = 1'b0; eqa = (bus.rna == 0) ? 32'd0 : bus.qa_rf;
            ehb = 1'b0; eqb = (bus.rnb == 0) ? 32'd0 : bus.qb_rf;
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (!eha && bus.rna != 0 && exp_q[i][36:32] == bus.rna) begin eha = 1'b1; eqa = exp_q[i][31:0]; end
                if (!ehb && bus.rnb != 0 && exp_q[i][36:32] == bus.rnb) begin ehb = 1'b1; eqb = exp_q[i][31:0]; end
            end
            checks++; if (bus.rdy !== erdy) begin errors++; $display("FAIL rnd_rdy cycle=%0d got=%0b want=%0b", c, bus.rdy, erdy); end
            checks++; if (bus.we !== (mcnt != 0)) begin errors++; $display("FAIL rnd_we cycle=%0d got=%0b want=%0b", c, bus.we, (mcnt != 0)); end
            if (mcnt != 0) begin
                checks++; if ({bus.wn, bus.d} !== exp_q[0]) begin errors++; $display("FAIL rnd_head cycle=%0d got=%0h want=%0h", c, {bus.wn, bus.d}, exp_q[0]); end
            end
            checks++; if (bus.qa !== eqa || bus.hita !== eha) begin errors++; $display("FAIL rnd_fwd_a cycle=%0d got=%0h/%0b want=%0h/%0b", c, bus.qa, bus.hita, eqa, eha); end
            checks++; if (bus.qb !== eqb || bus.hitb !== ehb) begin errors++; $display("FAIL rnd_fwd_b cycle=%0d got=%0h/%0b want=%0h/%0b", c, bus.qb, bus.hitb, eqb, ehb); end
            if (bus.we === 1'b1) dut_rf[bus.wn] = bus.d;
            if (mcnt != 0) void'(exp_q.pop_front());
            if (erdy && bus.v0 && bus.wn0 != 0) begin exp_q.push_back({bus.wn0, bus.d0}); exp_rf[bus.wn0] = bus.d0; end
            if (erdy && bus.v1 && bus.wn1 != 0) begin exp_q.push_back({bus.wn1, bus.d1}); exp_rf[bus.wn1] = bus.d1; end
            tick();
        end
        idle_inputs();
        #1;
        checks++; if (bus.empty !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL rnd_drained got empty=%0b model=%0d want 1 0", bus.empty, exp_q.size()); end
        for (int r = 1; r < 32; r++) begin
            checks++; if (dut_rf[r] !== exp_rf[r]) begin errors++; $display("FAIL rnd_rf r%0d got=%0h want=%0h", r, dut_rf[r], exp_rf[r]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_order();
        test_backpressure();
        test_r0();
        test_miss();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
